// File: rtl/shift_seq_ctrl_if.sv
// shift_seq_ctrl_if: command, response and shifter-drive signals for shift_seq_ctrl
// Ports (master = requester/consumer/shifter side, slave = controller side):
//   cmd_valid/cmd_ready/cmd_dir/cmd_data  load command handshake
//   shift_en/direction/data_in            drive to the external shifter
//   sr_data_out                           parallel contents of the shifter
//   rsp_valid/rsp_ready/rsp_data/rsp_match response handshake
//   busy                                   controller not idle
interface shift_seq_ctrl_if #(parameter int WIDTH = 8) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [WIDTH-1:0] cmd_data;
  logic             shift_en;
  logic             direction;
  logic             data_in;
  logic [WIDTH-1:0] sr_data_out;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_match;
  logic             busy;
  modport master (
    output cmd_valid, cmd_dir, cmd_data, sr_data_out, rsp_ready,
    input  cmd_ready, shift_en, direction, data_in, rsp_valid, rsp_data, rsp_match, busy
  );
  modport slave (
    input  cmd_valid, cmd_dir, cmd_data, sr_data_out, rsp_ready,
    output cmd_ready, shift_en, direction, data_in, rsp_valid, rsp_data, rsp_match, busy
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: serialises a command word into an external shifter and reports the captured contents
// Ports: clk (rising edge), reset (async, active-high), bus (shift_seq_ctrl_if.slave, WIDTH must match)
module shift_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             reset,
  shift_seq_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] data_q;
  logic             shift_en;
  logic             direction;
  logic             data_in;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_match;
  logic [CW-1:0]    nxt;
  logic [CW-1:0]    lidx;
  logic             first_bit;
  logic             next_bit;
  // Left shifts go MSB first, right shifts LSB first, so the shifter ends up holding the word as given.
  always_comb begin
    nxt       = cnt + 1'b1;
    lidx      = LAST - nxt;
    first_bit = bus.cmd_dir ? bus.cmd_data[0] : bus.cmd_data[WIDTH-1];
    next_bit  = direction ? data_q[nxt] : data_q[lidx];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      data_q    <= '0;
      shift_en  <= 1'b0;
      direction <= 1'b0;
      data_in   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_match <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.cmd_valid) begin
          data_q    <= bus.cmd_data;
          direction <= bus.cmd_dir;
          cnt       <= '0;
          shift_en  <= 1'b1;
          data_in   <= first_bit;
          state     <= SHIFT;
        end
        // cnt stops at LAST rather than wrapping; the final edge only drops shift_en.
        SHIFT: if (cnt == LAST) begin
          shift_en <= 1'b0;
          state    <= SETTLE;
        end else begin
          cnt     <= nxt;
          data_in <= next_bit;
        end
        // The shifter took its last bit on the previous edge, so its output is complete here.
        SETTLE: begin
          rsp_data  <= bus.sr_data_out;
          rsp_match <= (bus.sr_data_out == data_q);
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: if (bus.rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.shift_en  = shift_en;
  assign bus.direction = direction;
  assign bus.data_in   = data_in;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_data;
  assign bus.rsp_match = rsp_match;
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: directed self-checking bench for shift_seq_ctrl with a behavioural shifter
module tb_shift_seq_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic stuck = 1'b0;
  logic [7:0] sr = 8'h00;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  shift_seq_ctrl_if #(.WIDTH(8)) bus ();
  shift_seq_ctrl #(.WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always_ff @(posedge clk)
    if (bus.shift_en) sr <= bus.direction ? {bus.data_in, sr[7:1]} : {sr[6:0], bus.data_in};
  assign bus.sr_data_out = sr & ~{7'b0, stuck};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic dir, input logic [7:0] data);
    bus.cmd_valid = 1'b1;
    bus.cmd_dir   = dir;
    bus.cmd_data  = data;
    chk("send_ready", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask
  // Entered on the falling edge right after the accepting edge; seq lists bits first-to-last from MSB down.
  task automatic after_accept(input logic dir, input logic [7:0] seq, input logic [7:0] rd, input logic m);
    for (int i = 0; i < 8; i++) begin
      chk("shift_en", 32'(bus.shift_en), 32'd1);
      chk("data_in", 32'(bus.data_in), 32'(seq[7-i]));
      chk("direction", 32'(bus.direction), 32'(dir));
      chk("busy_shift", 32'(bus.busy), 32'd1);
      @(negedge clk);
    end
    chk("shift_en_off", 32'(bus.shift_en), 32'd0);
    chk("settle_no_rsp", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("rsp_data", 32'(bus.rsp_data), 32'(rd));
    chk("rsp_match", 32'(bus.rsp_match), 32'(m));
    chk("resp_ready_lo", 32'(bus.cmd_ready), 32'd0);
  endtask
  task automatic handshake(input logic dir, input logic [7:0] rd, input logic m);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("hs_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("hs_busy", 32'(bus.busy), 32'd0);
    chk("hs_rsp_data_hold", 32'(bus.rsp_data), 32'(rd));
    chk("hs_rsp_match_hold", 32'(bus.rsp_match), 32'(m));
    chk("hs_dir_hold", 32'(bus.direction), 32'(dir));
  endtask
  initial begin
    bus.cmd_valid = 1'b1;
    bus.cmd_dir   = 1'b1;
    bus.cmd_data  = 8'h5A;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_shift_en", 32'(bus.shift_en), 32'd0);
    chk("rst_direction", 32'(bus.direction), 32'd0);
    chk("rst_data_in", 32'(bus.data_in), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("rst_rsp_match", 32'(bus.rsp_match), 32'd0);
    bus.cmd_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 32'(bus.busy), 32'd0);
    chk("post_rst_ready", 32'(bus.cmd_ready), 32'd1);
    // left load of AA
    send(1'b0, 8'hAA);
    after_accept(1'b0, 8'hAA, 8'hAA, 1'b1);
    handshake(1'b0, 8'hAA, 1'b1);
    // right load of C3, LSB first
    send(1'b1, 8'hC3);
    after_accept(1'b1, 8'hC3, 8'hC3, 1'b1);
    handshake(1'b1, 8'hC3, 1'b1);
    // backpressure with a second command waiting
    send(1'b0, 8'h5A);
    after_accept(1'b0, 8'h5A, 8'h5A, 1'b1);
    bus.cmd_valid = 1'b1;
    bus.cmd_dir   = 1'b0;
    bus.cmd_data  = 8'h3C;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_rsp_data", 32'(bus.rsp_data), 32'h5A);
      chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("bp_not_yet", 32'(bus.busy), 32'd0);
    chk("bp_idle_ready", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("bp_accepted", 32'(bus.busy), 32'd1);
    after_accept(1'b0, 8'h3C, 8'h3C, 1'b1);
    handshake(1'b0, 8'h3C, 1'b1);
    // stuck-at-0 bit 0 in the shifter
    stuck = 1'b1;
    send(1'b0, 8'hFF);
    after_accept(1'b0, 8'hFF, 8'hFE, 1'b0);
    handshake(1'b0, 8'hFE, 1'b0);
    stuck = 1'b0;
    // reset after 3 bits of a right load
    send(1'b1, 8'h96);
    repeat (2) @(negedge clk);
    chk("pre_abort_shift", 32'(bus.shift_en), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_shift_en", 32'(bus.shift_en), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
    chk("abort_idle", 32'(bus.busy), 32'd0);
    chk("abort_rsp_data", 32'(bus.rsp_data), 32'd0);
    send(1'b1, 8'h96);
    after_accept(1'b1, 8'h69, 8'h96, 1'b1);
    handshake(1'b1, 8'h96, 1'b1);
    // back-to-back with cmd_valid held high
    bus.cmd_valid = 1'b1;
    bus.cmd_dir   = 1'b0;
    bus.cmd_data  = 8'h0F;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_data = 8'hF0;
    after_accept(1'b0, 8'h0F, 8'h0F, 1'b1);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("b2b_idle", 32'(bus.cmd_ready), 32'd1);
    chk("b2b_rsp_drop", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    after_accept(1'b0, 8'hF0, 8'hF0, 1'b1);
    handshake(1'b0, 8'hF0, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
